// File: rtl/pio_pkg.sv
// Shared register offsets and mode encodings for the bidirectional PIO with edge IRQ.
package pio_pkg;

    typedef enum logic [2:0] {
        ADDR_DATA = 3'd0,
        ADDR_DIR  = 3'd1,
        ADDR_MASK = 3'd2,
        ADDR_EDGE = 3'd3,
        ADDR_SET  = 3'd4,
        ADDR_CLR  = 3'd5,
        ADDR_RSV6 = 3'd6,
        ADDR_RSV7 = 3'd7
    } pio_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_sync_edge.sv
// Pin synchroniser chain plus a one-cycle history flop, yielding per-bit edge events.
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_sync_in,
    output logic [WIDTH-1:0] o_edge_evt
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_pins;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync_in = r_sync[SYNC_STAGES-1];

    // prev resets to 0, so a pin already high at reset release reads as a rise
    assign w_rise = o_sync_in & ~r_prev;
    assign w_fall = ~o_sync_in & r_prev;

    generate
        if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign o_edge_evt = w_rise | w_fall;
        end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign o_edge_evt = w_fall;
        end else begin : g_rise
            assign o_edge_evt = w_rise;
        end
    endgenerate

endmodule

// File: rtl/pio_bidir_irq.sv
// Avalon-MM bidirectional PIO: data/dir/set/clear registers, synchronised inputs,
// per-bit edge capture with write-1-to-clear, interrupt mask and a single IRQ.
module pio_bidir_irq
    import pio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               IRQ_TYPE    = IRQ_EDGE,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    inout  wire  [WIDTH-1:0] bidir_port
);

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_evt;
    logic [31:0]      w_rd;

    assign w_wr    = chipselect & ~write_n;
    assign w_wdata = writedata[WIDTH-1:0];
    assign w_clr   = (w_wr && (address == ADDR_EDGE)) ? w_wdata : '0;

    generate
        if (WIDTH < 32) begin : g_hi_bits
            logic w_unused_hi;
            assign w_unused_hi = |writedata[31:WIDTH];
        end
    endgenerate

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .i_pins     (bidir_port),
        .o_sync_in  (w_sync),
        .o_edge_evt (w_evt)
    );

    always_comb begin
        w_rd = '0;
        case (pio_addr_e'(address))
            ADDR_DATA: w_rd[WIDTH-1:0] = w_sync;
            ADDR_DIR:  w_rd[WIDTH-1:0] = r_dir;
            ADDR_MASK: w_rd[WIDTH-1:0] = r_mask;
            ADDR_EDGE: w_rd[WIDTH-1:0] = r_edge;
            default:   w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
            r_edge     <= '0;
            r_mask     <= '0;
            r_data_out <= RESET_OUT;
            r_dir      <= RESET_DIR;
        end else begin
            r_readdata <= w_rd;
            // a new event on a bit being cleared in the same cycle keeps it set
            r_edge     <= (r_edge & ~w_clr) | w_evt;
            if (w_wr) begin
                case (pio_addr_e'(address))
                    ADDR_DATA: r_data_out <= w_wdata;
                    ADDR_DIR:  r_dir      <= w_wdata;
                    ADDR_MASK: r_mask     <= w_wdata;
                    ADDR_SET:  r_data_out <= r_data_out | w_wdata;
                    ADDR_CLR:  r_data_out <= r_data_out & ~w_wdata;
                    default:   ;
                endcase
            end
        end
    end

    assign readdata = r_readdata;

    generate
        if (IRQ_TYPE == IRQ_EDGE) begin : g_irq_edge
            assign irq = |(r_edge & r_mask);
        end else begin : g_irq_level
            assign irq = |(w_sync & r_mask);
        end
    endgenerate

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_pad
            assign bidir_port[i] = r_dir[i] ? r_data_out[i] : 1'bz;
        end
    endgenerate

endmodule

// File: tb/tb_pio_bidir_irq.sv
// Three differently configured PIO instances on a shared bus, checked every cycle
// against a sample-history reference model plus directed constant expectations.
module tb_pio_bidir_irq;

    localparam int NI = 3;
    localparam int          CW  [NI] = '{32, 8, 16};
    localparam int          CS  [NI] = '{2, 4, 3};
    localparam int          CE  [NI] = '{0, 1, 2};
    localparam int          CI  [NI] = '{1, 0, 1};
    localparam logic [31:0] CRO [NI] = '{32'h0, 32'h3C, 32'h5};
    localparam logic [31:0] CRD [NI] = '{32'h0, 32'h0, 32'hF};

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;

    wire  [31:0] rd_a, rd_b, rd_c;
    wire         irq_a, irq_b, irq_c;
    wire  [31:0] pins_a;
    wire  [7:0]  pins_b;
    wire  [15:0] pins_c;

    logic [NI-1:0][31:0] tb_drv;
    logic [NI-1:0][31:0] tb_en;

    logic [31:0] m_out  [NI];
    logic [31:0] m_dir  [NI];
    logic [31:0] m_mask [NI];
    logic [31:0] m_edge [NI];
    logic [31:0] m_rd   [NI];
    logic        m_irq  [NI];
    logic [31:0] m_hist [NI][5];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 32; g++) begin : g_pa
        assign pins_a[g] = tb_en[0][g] ? tb_drv[0][g] : 1'bz;
    end
    for (genvar g = 0; g < 8; g++) begin : g_pb
        assign pins_b[g] = tb_en[1][g] ? tb_drv[1][g] : 1'bz;
    end
    for (genvar g = 0; g < 16; g++) begin : g_pc
        assign pins_c[g] = tb_en[2][g] ? tb_drv[2][g] : 1'bz;
    end

    pio_bidir_irq #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1),
                    .RESET_OUT(32'h0), .RESET_DIR(32'h0)) u_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a), .irq(irq_a),
        .bidir_port(pins_a));

    pio_bidir_irq #(.WIDTH(8), .SYNC_STAGES(4), .EDGE_TYPE(1), .IRQ_TYPE(0),
                    .RESET_OUT(8'h3C), .RESET_DIR(8'h00)) u_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b), .irq(irq_b),
        .bidir_port(pins_b));

    pio_bidir_irq #(.WIDTH(16), .SYNC_STAGES(3), .EDGE_TYPE(2), .IRQ_TYPE(1),
                    .RESET_OUT(16'h0005), .RESET_DIR(16'h000F)) u_c (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_c), .irq(irq_c),
        .bidir_port(pins_c));

    function automatic logic [31:0] wmask(input int w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_out[i]  = CRO[i];
            m_dir[i]  = CRD[i];
            m_mask[i] = '0;
            m_edge[i] = '0;
            m_rd[i]   = '0;
            m_irq[i]  = 1'b0;
            for (int j = 0; j < 5; j++) m_hist[i][j] = '0;
        end
    endtask

    // Next state from the inputs presented before the coming rising edge.
    task automatic model_step();
        logic [31:0] wm, pad, cur, old, evt, wd;
        logic        wr;
        if (reset) begin
            model_reset();
            return;
        end
        wr = chipselect & ~write_n;
        for (int i = 0; i < NI; i++) begin
            wm  = wmask(CW[i]);
            pad = ((m_dir[i] & m_out[i]) | (~m_dir[i] & tb_drv[i])) & wm;
            cur = m_hist[i][CS[i]-1];
            old = m_hist[i][CS[i]];
            case (CE[i])
                0:       evt = cur & ~old;
                1:       evt = ~cur & old;
                default: evt = cur ^ old;
            endcase
            wd = writedata & wm;
            case (address)
                3'd0:    m_rd[i] = cur;
                3'd1:    m_rd[i] = m_dir[i];
                3'd2:    m_rd[i] = m_mask[i];
                3'd3:    m_rd[i] = m_edge[i];
                default: m_rd[i] = '0;
            endcase
            if (wr && address == 3'd3) m_edge[i] = m_edge[i] & ~wd;
            m_edge[i] = m_edge[i] | evt;
            if (wr) begin
                case (address)
                    3'd0:    m_out[i]  = wd;
                    3'd1:    m_dir[i]  = wd;
                    3'd2:    m_mask[i] = wd;
                    3'd4:    m_out[i]  = m_out[i] | wd;
                    3'd5:    m_out[i]  = m_out[i] & ~wd;
                    default: ;
                endcase
            end
            for (int j = 4; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
            m_hist[i][0] = pad;
            m_irq[i] = (CI[i] == 1) ? |(m_edge[i] & m_mask[i])
                                    : |(m_hist[i][CS[i]-1] & m_mask[i]);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("rd_a", rd_a, m_rd[0]);
        chk("rd_b", rd_b, m_rd[1]);
        chk("rd_c", rd_c, m_rd[2]);
        chk("irq_a", {31'b0, irq_a}, {31'b0, m_irq[0]});
        chk("irq_b", {31'b0, irq_b}, {31'b0, m_irq[1]});
        chk("irq_c", {31'b0, irq_c}, {31'b0, m_irq[2]});
        chk("pad_a", pins_a & m_dir[0], m_out[0] & m_dir[0]);
        chk("pad_b", {24'b0, pins_b} & m_dir[1], m_out[1] & m_dir[1]);
        chk("pad_c", {16'b0, pins_c} & m_dir[2], m_out[2] & m_dir[2]);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Hand pins over between bench and DUT without a glitch on the pad.
    task automatic set_dir(input logic [31:0] d);
        logic [31:0] wm, nd, chg;
        for (int i = 0; i < NI; i++) begin
            wm        = wmask(CW[i]);
            nd        = d & wm;
            chg       = nd ^ m_dir[i];
            tb_drv[i] = (tb_drv[i] & ~chg) | (m_out[i] & chg);
            tb_en[i]  = tb_en[i] | (~nd & wm);
        end
        wr(3'd1, d);
        for (int i = 0; i < NI; i++) tb_en[i] = ~d & wmask(CW[i]);
    endtask

    task automatic assert_reset_and_check(input string tag);
        #2 reset = 1'b1;
        for (int i = 0; i < NI; i++) tb_en[i] = ~CRD[i] & wmask(CW[i]);
        model_reset();
        #1;
        chk({tag, "_rd_a"}, rd_a, 32'h0);
        chk({tag, "_rd_b"}, rd_b, 32'h0);
        chk({tag, "_rd_c"}, rd_c, 32'h0);
        chk({tag, "_irq"}, {29'b0, irq_a, irq_b, irq_c}, 32'h0);
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        tb_drv     = '0;
        for (int i = 0; i < NI; i++) tb_en[i] = ~CRD[i] & wmask(CW[i]);
        model_reset();
        #1 reset = 1'b1;
        repeat (3) cyc();
        chk("rst_rd", rd_a | rd_b | rd_c, 32'h0);
        chk("rst_irq", {29'b0, irq_a, irq_b, irq_c}, 32'h0);
        reset = 1'b0;

        // C drives bits 0 and 2 high out of reset: seen as rising edges
        address = 3'd3;
        repeat (5) cyc();
        chk("rst_rise_c", rd_c, 32'h5);

        // data/direction basics
        set_dir(32'h0000_00FF);
        wr(3'd0, 32'h0000_00A5);
        chk("t1_pins", {24'b0, pins_a[7:0]}, 32'hA5);
        address = 3'd0;
        repeat (5) cyc();
        chk("t1_rd_data", rd_a, 32'h0000_00A5);
        address = 3'd1;
        cyc();
        chk("t1_rd_dir", rd_a, 32'h0000_00FF);

        // set / clear
        wr(3'd0, 32'h0F);
        wr(3'd4, 32'hF0);
        chk("t2_set", {24'b0, pins_a[7:0]}, 32'hFF);
        wr(3'd5, 32'h3C);
        chk("t2_clr", {24'b0, pins_a[7:0]}, 32'hC3);
        address = 3'd0;
        repeat (4) cyc();
        chk("t2_rd_data", rd_a, 32'hC3);
        address = 3'd4;
        cyc();
        chk("t2_rd_set", rd_a, 32'h0);
        address = 3'd5;
        cyc();
        chk("t2_rd_clr", rd_a, 32'h0);

        // rising-edge capture latency and write-1-to-clear
        set_dir(32'h0);
        tb_drv[0] = '0;
        wr(3'd2, 32'h1);
        repeat (6) cyc();
        wr(3'd3, 32'hFFFF_FFFF);
        chk("t3_irq_idle", {31'b0, irq_a}, 32'h0);
        address   = 3'd3;
        tb_drv[0][0] = 1'b1;
        cyc();
        chk("t3_irq_k", {31'b0, irq_a}, 32'h0);
        cyc();
        chk("t3_irq_k1", {31'b0, irq_a}, 32'h0);
        cyc();
        chk("t3_irq_k2", {31'b0, irq_a}, 32'h1);
        cyc();
        chk("t3_capture", rd_a, 32'h1);
        wr(3'd3, 32'h1);
        chk("t3_irq_clr", {31'b0, irq_a}, 32'h0);

        // clear and new edge in the same cycle: set wins
        tb_drv[0][2] = 1'b1;
        cyc();
        cyc();
        wr(3'd3, 32'h4);
        address = 3'd3;
        cyc();
        chk("t4_set_wins", rd_a & 32'h4, 32'h4);
        wr(3'd3, 32'h4);
        address = 3'd3;
        cyc();
        chk("t4_cleared", rd_a, 32'h0);

        // any-edge capture independent of mask
        wr(3'd2, 32'h0);
        wr(3'd3, 32'hFFFF_FFFF);
        tb_drv[2][5] = ~tb_drv[2][5];
        repeat (5) cyc();
        chk("t5_irq_masked", {31'b0, irq_c}, 32'h0);
        address = 3'd3;
        cyc();
        chk("t5_capture", rd_c & 32'h20, 32'h20);
        wr(3'd2, 32'h20);
        chk("t5_irq_unmask", {31'b0, irq_c}, 32'h1);

        // narrow instance, level irq, reset mid-traffic
        set_dir(32'hFFFF_FFFF);
        address = 3'd1;
        cyc();
        chk("t6_dir_b", rd_b, 32'h0000_00FF);
        chk("t6_dir_a", rd_a, 32'hFFFF_FFFF);
        set_dir(32'h0);
        wr(3'd2, 32'h08);
        tb_drv[1] = '0;
        repeat (6) cyc();
        chk("t6_irq_low", {31'b0, irq_b}, 32'h0);
        tb_drv[1][3] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cyc();
            chk("t6_irq_lat", {31'b0, irq_b}, 32'h0);
        end
        cyc();
        chk("t6_irq_high", {31'b0, irq_b}, 32'h1);
        assert_reset_and_check("t6_reset");

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            int r;
            int x;
            r = $urandom_range(0, 9);
            if (r < 3) begin
                tb_drv[$urandom_range(0, NI-1)] = $urandom;
                address = 3'($urandom_range(0, 7));
                cyc();
            end else if (r < 8) begin
                x = $urandom_range(0, 6);
                wr((x == 0) ? 3'd0 : 3'(x + 1), $urandom);
            end else if (r == 8) begin
                set_dir($urandom);
            end else begin
                chipselect = $urandom_range(0, 1) == 1;
                write_n    = ~chipselect;
                if (!chipselect) write_n = 1'b0;
                address    = 3'($urandom_range(0, 7));
                writedata  = $urandom;
                chipselect = 1'b0;
                cyc();
                write_n    = 1'b1;
            end
        end

        assert_reset_and_check("end_reset");
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
